gpr_mp: RTL

Parametrised multi-port general-purpose register file for the MIPS datapath. It replaces the fixed 2-read/1-write register file with the following features:
- configurable data width, depth and read-port count;
- two prioritised write ports;
- optional hardwired-zero r0;
- optional same-cycle write-to-read bypass;
- a self-timed reset initialisation sequence that loads each register with its own index.

It sits between decode (read addresses) and writeback (write ports) and runs directly on the core clock.

---
 rtl/gpr_mp.sv | 100 ++++++++++
 1 files changed

// File: rtl/gpr_mp.sv
// gpr_mp: parametrised multi-port general-purpose register file.
//   Two prioritised write ports (port 1 wins on an address collision),
//   NR combinational read ports, optional hardwired-zero r0, optional
//   same-cycle write-to-read bypass. After reset a self-timed sequence
//   loads every register with its own index; busy is high until it ends.
// Ports:
//   clk            core clock, rising edge
//   reset          synchronous, active-high; restarts the init sequence
//   busy           high while the init sequence runs (registered)
//   we0/wa0/wd0    write port 0
//   we1/wa1/wd1    write port 1 (priority over port 0)
//   ra             packed read addresses, port k = ra[k*AW +: AW]
//   rd             packed read data,      port k = rd[k*DW +: DW]
module gpr_mp #(
  parameter int DW      = 32,
  parameter int AW      = 5,
  parameter int NR      = 2,
  parameter int R0_ZERO = 1,
  parameter int BYPASS  = 1
) (
  input  logic             clk,
  input  logic             reset,
  output logic             busy,
  input  logic             we0,
  input  logic [AW-1:0]    wa0,
  input  logic [DW-1:0]    wd0,
  input  logic             we1,
  input  logic [AW-1:0]    wa1,
  input  logic [DW-1:0]    wd1,
  input  logic [NR*AW-1:0] ra,
  output logic [NR*DW-1:0] rd
);

  localparam int DEPTH = 2 ** AW;

  typedef enum logic {
    INIT,
    READY
  } state_t;

  state_t        state_q;
  logic [AW-1:0] cnt_q;
  logic          busy_q;
  logic [DW-1:0] mem_q [DEPTH];

  logic [DW-1:0] init_val;
  logic          keep0;
  logic          keep1;

  always_comb begin
    // Register index zero-extended or truncated to the data width.
    init_val = DW'(cnt_q);
    keep0    = we0 && !((R0_ZERO != 0) && (wa0 == '0));
    keep1    = we1 && !((R0_ZERO != 0) && (wa1 == '0));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= INIT;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      case (state_q)
        INIT: begin
          mem_q[cnt_q] <= init_val;
          // Counter saturates at DEPTH-1 instead of wrapping.
          if (cnt_q == '1) begin
            state_q <= READY;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        READY: begin
          if (keep0) mem_q[wa0] <= wd0;
          // Issued after port 0 so that port 1 wins a same-address collision.
          if (keep1) mem_q[wa1] <= wd1;
        end
      endcase
    end
  end

  assign busy = busy_q;

  always_comb begin
    rd = '0;
    for (int unsigned k = 0; k < NR; k++) begin
      if (!busy_q && !((R0_ZERO != 0) && (ra[k*AW +: AW] == '0))) begin
        if ((BYPASS != 0) && we1 && (wa1 == ra[k*AW +: AW])) begin
          rd[k*DW +: DW] = wd1;
        end else if ((BYPASS != 0) && we0 && (wa0 == ra[k*AW +: AW])) begin
          rd[k*DW +: DW] = wd0;
        end else begin
          rd[k*DW +: DW] = mem_q[ra[k*AW +: AW]];
        end
      end
    end
  end

endmodule
